// File: rtl/decode_stage.sv
// ID stage of the five-stage MIPS pipeline: latches the IF->ID bus, decodes the integer subset,
// stalls on RAW hazards (no forwarding), resolves branches/jumps and drives the ID->EXE bus.
module decode_stage #(
  parameter int unsigned INST_W   = 32,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                IF_over,
  input  logic [2*INST_W-1:0] IF_ID_bus,
  output logic                next_fetch,
  output logic [4:0]          rs_addr,
  output logic [4:0]          rt_addr,
  input  logic [INST_W-1:0]   rs_value,
  input  logic [INST_W-1:0]   rt_value,
  input  logic [4:0]          EXE_wdest,
  input  logic [4:0]          MEM_wdest,
  input  logic [4:0]          WB_wdest,
  input  logic                EXE_allow_in,
  input  logic                cancel,
  output logic                ID_valid,
  output logic                ID_allow_in,
  output logic                ID_over,
  output logic [INST_W:0]     jbr_bus,
  output logic [4*INST_W+10:0] ID_EXE_bus,
  output logic [INST_W-1:0]   ID_pc,
  output logic [INST_W-1:0]   ID_inst
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2,  ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4,  ALU_NOR = 4'd5,  ALU_SLT = 4'd6,  ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,  ALU_SRL = 4'd9,  ALU_SRA = 4'd10, ALU_LUI = 4'd11
  } alu_op_t;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;
  logic [INST_W-1:0] simm, zimm, br_target, j_target;

  alu_op_t           alu_op;
  logic [INST_W-1:0] src1, src2, jtarget;
  logic [4:0]        wdest;
  logic              ld, st, use_rs, use_rt, jump, jcond;
  logic              rs_hit, rt_hit, hazard, jbr_taken;

  assign next_fetch = IF_over & ID_allow_in & ~cancel;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ID_valid <= 1'b0;
      ID_pc    <= '0;
      ID_inst  <= '0;
    end else begin
      if (cancel)           ID_valid <= 1'b0;
      else if (ID_allow_in) ID_valid <= IF_over;
      if (next_fetch) begin
        ID_pc   <= IF_ID_bus[2*INST_W-1:INST_W];
        ID_inst <= IF_ID_bus[INST_W-1:0];
      end
    end
  end

  assign op    = ID_inst[31:26];
  assign rs    = ID_inst[25:21];
  assign rt    = ID_inst[20:16];
  assign rd    = ID_inst[15:11];
  assign sa    = ID_inst[10:6];
  assign funct = ID_inst[5:0];
  assign imm   = ID_inst[15:0];

  assign rs_addr   = rs;
  assign rt_addr   = rt;
  assign simm      = {{16{imm[15]}}, imm};
  assign zimm      = {16'h0, imm};
  assign br_target = ID_pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  assign j_target  = {ID_pc[31:28], ID_inst[25:0], 2'b00};

  always_comb begin
    alu_op  = ALU_ADD;
    src1    = rs_value;
    src2    = rt_value;
    wdest   = '0;
    ld      = 1'b0;
    st      = 1'b0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    jump    = 1'b0;
    jcond   = 1'b0;
    jtarget = '0;
    case (op)
      6'h00: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        wdest  = rd;
        case (funct)
          6'h21: alu_op = ALU_ADD;
          6'h23: alu_op = ALU_SUB;
          6'h24: alu_op = ALU_AND;
          6'h25: alu_op = ALU_OR;
          6'h26: alu_op = ALU_XOR;
          6'h27: alu_op = ALU_NOR;
          6'h2a: alu_op = ALU_SLT;
          6'h2b: alu_op = ALU_SLTU;
          6'h00: begin alu_op = ALU_SLL; src1 = {27'b0, sa}; use_rs = 1'b0; end
          6'h02: begin alu_op = ALU_SRL; src1 = {27'b0, sa}; use_rs = 1'b0; end
          6'h03: begin alu_op = ALU_SRA; src1 = {27'b0, sa}; use_rs = 1'b0; end
          6'h08: begin
            use_rt  = 1'b0;
            wdest   = '0;
            jump    = 1'b1;
            jcond   = 1'b1;
            jtarget = rs_value;
          end
          default: begin use_rs = 1'b0; use_rt = 1'b0; wdest = '0; end
        endcase
      end
      // REGIMM: rt=0 is BLTZ, rt=1 is BGEZ; rt[0] inverts the sign test
      6'h01: if (rt[4:1] == 4'b0) begin
        use_rs  = 1'b1;
        jump    = 1'b1;
        jcond   = rs_value[31] ^ rt[0];
        jtarget = br_target;
      end
      6'h02: begin jump = 1'b1; jcond = 1'b1; jtarget = j_target; end
      6'h03: begin
        jump    = 1'b1;
        jcond   = 1'b1;
        jtarget = j_target;
        wdest   = LINK_REG;
        src1    = ID_pc;
        src2    = 32'd8;
      end
      6'h04, 6'h05: begin
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        jump    = 1'b1;
        jcond   = (rs_value == rt_value) ^ op[0];
        jtarget = br_target;
      end
      6'h09: begin use_rs = 1'b1; wdest = rt; src2 = simm; end
      6'h0a: begin use_rs = 1'b1; wdest = rt; src2 = simm; alu_op = ALU_SLT; end
      6'h0c: begin use_rs = 1'b1; wdest = rt; src2 = zimm; alu_op = ALU_AND; end
      6'h0d: begin use_rs = 1'b1; wdest = rt; src2 = zimm; alu_op = ALU_OR;  end
      6'h0e: begin use_rs = 1'b1; wdest = rt; src2 = zimm; alu_op = ALU_XOR; end
      6'h0f: begin wdest = rt; src1 = '0; src2 = {imm, 16'h0}; alu_op = ALU_LUI; end
      6'h23: begin use_rs = 1'b1; wdest = rt; src2 = simm; ld = 1'b1; end
      6'h2b: begin use_rs = 1'b1; use_rt = 1'b1; src2 = simm; st = 1'b1; end
      default: ;
    endcase
  end

  // A zero register never matches, so "nonzero wdest" falls out of the rs/rt != 0 test
  assign rs_hit = (rs != 5'd0) && (rs == EXE_wdest || rs == MEM_wdest || rs == WB_wdest);
  assign rt_hit = (rt != 5'd0) && (rt == EXE_wdest || rt == MEM_wdest || rt == WB_wdest);
  assign hazard = (use_rs & rs_hit) | (use_rt & rt_hit);

  assign ID_over     = ID_valid & ~hazard & ~cancel;
  assign ID_allow_in = ~ID_valid | (ID_over & EXE_allow_in);

  assign jbr_taken  = ID_over & jump & jcond;
  assign jbr_bus    = {jbr_taken, jbr_taken ? jtarget : {INST_W{1'b0}}};
  assign ID_EXE_bus = {alu_op, src1, src2, ld, st, rt_value, wdest, ID_pc};

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage against a mnemonic-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        resetn, IF_over, next_fetch, EXE_allow_in, cancel;
  logic        ID_valid, ID_allow_in, ID_over;
  logic [63:0] IF_ID_bus;
  logic [4:0]  rs_addr, rt_addr, EXE_wdest, MEM_wdest, WB_wdest;
  logic [31:0] rs_value, rt_value, ID_pc, ID_inst;
  logic [32:0] jbr_bus;
  logic [138:0] ID_EXE_bus;

  always #5 clk = ~clk;

  decode_stage #(.INST_W(32), .LINK_REG(5'd31)) dut (
    .clk(clk), .resetn(resetn), .IF_over(IF_over), .IF_ID_bus(IF_ID_bus),
    .next_fetch(next_fetch), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_value(rs_value), .rt_value(rt_value), .EXE_wdest(EXE_wdest),
    .MEM_wdest(MEM_wdest), .WB_wdest(WB_wdest), .EXE_allow_in(EXE_allow_in),
    .cancel(cancel), .ID_valid(ID_valid), .ID_allow_in(ID_allow_in),
    .ID_over(ID_over), .jbr_bus(jbr_bus), .ID_EXE_bus(ID_EXE_bus),
    .ID_pc(ID_pc), .ID_inst(ID_inst)
  );

  logic [31:0] regs [32];
  assign rs_value = regs[rs_addr];
  assign rt_value = regs[rt_addr];

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4,
    A_NOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7, A_SLL = 4'd8, A_SRL = 4'd9, A_SRA = 4'd10,
    A_LUI = 4'd11;

  typedef enum {M_NOP, M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU, M_SLL, M_SRL,
    M_SRA, M_JR, M_ADDIU, M_ANDI, M_ORI, M_XORI, M_SLTI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE,
    M_BGEZ, M_BLTZ, M_J, M_JAL} mn_t;

  int unsigned total = 0, bad = 0;

  task automatic check(input string tag, input logic [138:0] got, input logic [138:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd, logic [4:0] sa);
    return {6'd0, rs, rt, rd, sa, fn};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic mn_t classify(logic [31:0] i);
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h21: return M_ADDU;  6'h23: return M_SUBU;  6'h24: return M_AND;
        6'h25: return M_OR;    6'h26: return M_XOR;   6'h27: return M_NOR;
        6'h2a: return M_SLT;   6'h2b: return M_SLTU;  6'h00: return M_SLL;
        6'h02: return M_SRL;   6'h03: return M_SRA;   6'h08: return M_JR;
        default: return M_NOP;
      endcase
    end
    case (i[31:26])
      6'h01: return (i[20:16] == 5'd1) ? M_BGEZ : (i[20:16] == 5'd0) ? M_BLTZ : M_NOP;
      6'h02: return M_J;     6'h03: return M_JAL;   6'h04: return M_BEQ;
      6'h05: return M_BNE;   6'h09: return M_ADDIU; 6'h0a: return M_SLTI;
      6'h0c: return M_ANDI;  6'h0d: return M_ORI;   6'h0e: return M_XORI;
      6'h0f: return M_LUI;   6'h23: return M_LW;    6'h2b: return M_SW;
      default: return M_NOP;
    endcase
  endfunction

  // Reference state and expected outputs
  logic        m_valid;
  logic [31:0] m_pc, m_inst;
  logic        e_over, e_allow, e_nf;
  logic [32:0] e_jbr;
  logic [138:0] e_bus;

  function automatic logic pend(logic [4:0] r);
    return r != 0 && (r == EXE_wdest || r == MEM_wdest || r == WB_wdest);
  endfunction

  task automatic model_eval();
    mn_t m;
    logic [4:0] rs, rt, rd, wd;
    logic [31:0] a, b, simm, zimm, tgt, btgt, jtgt;
    logic [3:0] alu;
    logic ld, st, rrs, rrt, taken, haz;
    m = classify(m_inst);
    rs = m_inst[25:21]; rt = m_inst[20:16]; rd = m_inst[15:11];
    simm = 32'($signed(m_inst[15:0]));
    zimm = 32'(m_inst[15:0]);
    btgt = m_pc + 32'd4 + simm * 32'd4;
    jtgt = (m_pc & 32'hF000_0000) + 32'(m_inst[25:0]) * 32'd4;
    a = regs[rs]; b = regs[rt]; alu = A_ADD; ld = 0; st = 0; wd = 0;
    rrs = 0; rrt = 0; taken = 0; tgt = 0;
    case (m)
      M_ADDU: begin alu = A_ADD;  wd = rd; rrs = 1; rrt = 1; end
      M_SUBU: begin alu = A_SUB;  wd = rd; rrs = 1; rrt = 1; end
      M_AND:  begin alu = A_AND;  wd = rd; rrs = 1; rrt = 1; end
      M_OR:   begin alu = A_OR;   wd = rd; rrs = 1; rrt = 1; end
      M_XOR:  begin alu = A_XOR;  wd = rd; rrs = 1; rrt = 1; end
      M_NOR:  begin alu = A_NOR;  wd = rd; rrs = 1; rrt = 1; end
      M_SLT:  begin alu = A_SLT;  wd = rd; rrs = 1; rrt = 1; end
      M_SLTU: begin alu = A_SLTU; wd = rd; rrs = 1; rrt = 1; end
      M_SLL:  begin alu = A_SLL; wd = rd; rrt = 1; a = 32'(m_inst[10:6]); end
      M_SRL:  begin alu = A_SRL; wd = rd; rrt = 1; a = 32'(m_inst[10:6]); end
      M_SRA:  begin alu = A_SRA; wd = rd; rrt = 1; a = 32'(m_inst[10:6]); end
      M_JR:   begin rrs = 1; taken = 1; tgt = regs[rs]; end
      M_ADDIU: begin wd = rt; rrs = 1; b = simm; end
      M_SLTI: begin alu = A_SLT; wd = rt; rrs = 1; b = simm; end
      M_ANDI: begin alu = A_AND; wd = rt; rrs = 1; b = zimm; end
      M_ORI:  begin alu = A_OR;  wd = rt; rrs = 1; b = zimm; end
      M_XORI: begin alu = A_XOR; wd = rt; rrs = 1; b = zimm; end
      M_LUI:  begin alu = A_LUI; wd = rt; a = 0; b = zimm << 16; end
      M_LW:   begin ld = 1; wd = rt; rrs = 1; b = simm; end
      M_SW:   begin st = 1; rrs = 1; rrt = 1; b = simm; end
      M_BEQ:  begin rrs = 1; rrt = 1; taken = (regs[rs] == regs[rt]); tgt = btgt; end
      M_BNE:  begin rrs = 1; rrt = 1; taken = (regs[rs] != regs[rt]); tgt = btgt; end
      M_BGEZ: begin rrs = 1; taken = ($signed(regs[rs]) >= 0); tgt = btgt; end
      M_BLTZ: begin rrs = 1; taken = ($signed(regs[rs]) < 0); tgt = btgt; end
      M_J:    begin taken = 1; tgt = jtgt; end
      M_JAL:  begin taken = 1; tgt = jtgt; wd = 5'd31; a = m_pc; b = 32'd8; end
      default: ;
    endcase
    haz     = (rrs && pend(rs)) || (rrt && pend(rt));
    e_over  = m_valid && !haz && !cancel;
    e_allow = !m_valid || (e_over && EXE_allow_in);
    e_nf    = IF_over && e_allow && !cancel;
    e_jbr   = (e_over && taken) ? {1'b1, tgt} : 33'd0;
    e_bus   = {alu, a, b, ld, st, regs[rt], wd, m_pc};
  endtask

  task automatic apply(input logic ifo, input logic [63:0] bus, input logic [4:0] ew,
                       input logic [4:0] mw, input logic [4:0] ww, input logic eai,
                       input logic cn);
    @(negedge clk);
    IF_over = ifo; IF_ID_bus = bus; EXE_wdest = ew; MEM_wdest = mw; WB_wdest = ww;
    EXE_allow_in = eai; cancel = cn;
    #1;
    model_eval();
    check("valid", ID_valid, m_valid);
    check("allow_in", ID_allow_in, e_allow);
    check("over", ID_over, e_over);
    check("next_fetch", next_fetch, e_nf);
    check("jbr_bus", jbr_bus, e_jbr);
    check("id_exe_bus", ID_EXE_bus, e_bus);
    check("id_pc", ID_pc, m_pc);
    check("id_inst", ID_inst, m_inst);
    check("rs_addr", rs_addr, m_inst[25:21]);
    check("rt_addr", rt_addr, m_inst[20:16]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (cancel) m_valid = 1'b0;
    else if (e_allow) m_valid = IF_over;
    if (e_nf) begin
      m_pc = IF_ID_bus[63:32];
      m_inst = IF_ID_bus[31:0];
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] fns [12];
    logic [5:0] ops [10];
    logic [4:0] rs, rt, rd;
    int unsigned k;
    fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08};
    ops = '{6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05};
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 27);
    if (k < 12) return enc_r(fns[k], rs, rt, rd, 5'($urandom));
    if (k < 22) return enc_i(ops[k-12], rs, rt, 16'($urandom));
    if (k == 22) return enc_i(6'h01, rs, 5'($urandom_range(0, 2)), 16'($urandom));
    if (k == 23) return {6'h02, 26'($urandom)};
    if (k == 24) return {6'h03, 26'($urandom)};
    return $urandom;
  endfunction

  function automatic logic [4:0] rand_wd();
    return ($urandom % 3 == 0) ? 5'($urandom_range(0, 7)) : 5'd0;
  endfunction

  logic [31:0] jal_sum;
  logic [63:0] bus_x;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; IF_over = 0; IF_ID_bus = '0; EXE_wdest = 0; MEM_wdest = 0; WB_wdest = 0;
    EXE_allow_in = 1; cancel = 0;
    regs[0] = 32'd0;
    for (int r = 1; r < 32; r++) regs[r] = $urandom;
    regs[8] = regs[7] + 32'd1;
    m_valid = 0; m_pc = 0; m_inst = 0;
    repeat (3) @(posedge clk);

    // Reset state
    apply(0, '0, 0, 0, 0, 1, 0);
    check("rst_jbr", jbr_bus, 33'd0);
    check("rst_over", ID_over, 1'b0);
    check("rst_allow", ID_allow_in, 1'b1);
    resetn = 1'b1;
    tick();

    // ADDIU $2,$0,5 at 0x34
    apply(1, {32'h34, enc_i(6'h09, 5'd0, 5'd2, 16'd5)}, 0, 0, 0, 1, 0);
    check("addiu_nf", next_fetch, 1'b1);
    tick();
    // ADDU $3,$2,$2 follows, accepted while ADDIU drains
    apply(1, {32'h38, enc_r(6'h21, 5'd2, 5'd2, 5'd3, 5'd0)}, 0, 0, 0, 1, 0);
    check("addiu_over", ID_over, 1'b1);
    check("addiu_alu", ID_EXE_bus[138:135], A_ADD);
    check("addiu_src1", ID_EXE_bus[134:103], 32'd0);
    check("addiu_src2", ID_EXE_bus[102:71], 32'd5);
    check("addiu_wdest", ID_EXE_bus[36:32], 5'd2);
    check("addiu_pc", ID_EXE_bus[31:0], 32'h34);
    tick();

    // $2 pending in EXE, then MEM, then WB: stall until all clear
    for (int k = 0; k < 8; k++) begin
      apply(1, {32'h40, enc_i(6'h04, 5'd7, 5'd7, 16'hFFFC)},
            (k < 3) ? 5'd2 : 5'd0, (k >= 3 && k < 5) ? 5'd2 : 5'd0,
            (k >= 5 && k < 7) ? 5'd2 : 5'd0, 1, 0);
      if (k < 7) begin
        check("stall_over", ID_over, 1'b0);
        check("stall_allow", ID_allow_in, 1'b0);
        check("stall_nf", next_fetch, 1'b0);
      end else begin
        check("unstall_over", ID_over, 1'b1);
      end
      tick();
    end

    // BEQ $7,$7 taken back to 0x34; then BEQ $7,$8 not taken
    apply(1, {32'h44, enc_i(6'h04, 5'd7, 5'd8, 16'hFFFC)}, 0, 0, 0, 1, 0);
    check("beq_taken", jbr_bus, {1'b1, 32'h34});
    tick();
    apply(1, {32'h1000_0050, 6'h03, 26'h20}, 0, 0, 0, 1, 0);
    check("beq_not_taken", jbr_bus, 33'd0);
    tick();

    // JAL held with EXE blocked for 5 cycles, then released
    bus_x = {32'h2000, enc_i(6'h0d, 5'd1, 5'd4, 16'h00FF)};
    for (int k = 0; k < 5; k++) begin
      apply(1, bus_x, 0, 0, 0, 0, 0);
      check("jal_target", jbr_bus, {1'b1, 32'h1000_0080});
      check("jal_wdest", ID_EXE_bus[36:32], 5'd31);
      jal_sum = ID_EXE_bus[134:103] + ID_EXE_bus[102:71];
      check("jal_link", jal_sum, 32'h1000_0058);
      check("blk_over", ID_over, 1'b1);
      check("blk_allow", ID_allow_in, 1'b0);
      check("blk_inst", ID_inst, {6'h03, 26'h20});
      tick();
    end
    apply(1, bus_x, 0, 0, 0, 1, 0);
    check("release_nf", next_fetch, 1'b1);
    tick();
    apply(1, {32'h3000, enc_i(6'h09, 5'd0, 5'd5, 16'd1)}, 0, 0, 0, 1, 1);
    check("release_inst", ID_inst, bus_x[31:0]);
    check("cancel_nf", next_fetch, 1'b0);
    tick();
    apply(0, '0, 0, 0, 0, 1, 0);
    check("cancel_valid", ID_valid, 1'b0);
    check("cancel_noload", ID_inst, bus_x[31:0]);
    tick();

    // Async reset in the middle of a hazard stall
    apply(1, {32'h50, enc_r(6'h21, 5'd2, 5'd2, 5'd3, 5'd0)}, 0, 0, 0, 1, 0);
    tick();
    apply(0, '0, 5'd2, 0, 0, 1, 0);
    check("pre_rst_stall", ID_allow_in, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check("arst_valid", ID_valid, 1'b0);
    check("arst_allow", ID_allow_in, 1'b1);
    check("arst_inst", ID_inst, 32'd0);
    m_valid = 0; m_pc = 0; m_inst = 0;
    @(posedge clk);
    #2 resetn = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int r = 1; r < 32; r++)
        regs[r] = ($urandom % 4 == 0) ? $urandom : 32'($urandom_range(0, 3));
      apply(($urandom % 4) != 0, {$urandom, rand_inst()}, rand_wd(), rand_wd(), rand_wd(),
            ($urandom % 4) != 0, ($urandom % 16) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
